move_controller: RTL and testbench

MOVE_CONTROLLER -- requirements
Module: move_controller

---
 rtl/move_controller.sv | 147 ++++++++++++++
 tb/tb_move_controller.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/move_controller.sv
// Drop-move sequencer for a connect-style board: validates a requested column drop,
// issues the board write and the turn toggle, and tracks column heights and fill.
//   state   | meaning
//   IDLE    | waiting for drop_req
//   CHECK   | latched move is being validated
//   WRITE   | board write strobe for the accepted move
//   ADVANCE | turn tracker toggle pulse
//   REJECT  | illegal move pulse, nothing written
module move_controller #(
    parameter int COLS = 7,
    parameter int ROWS = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            new_game,
    input  logic            drop_req,
    input  logic [2:0]      drop_col,
    input  logic [1:0]      piece,
    output logic            wr_en,
    output logic [2:0]      wr_row,
    output logic [2:0]      wr_col,
    output logic [1:0]      wr_data,
    output logic            turn_advance,
    output logic            reject,
    output logic            busy,
    output logic [COLS-1:0] col_full,
    output logic            board_full
);

    localparam int CELLS = COLS * ROWS;
    localparam int PW    = $clog2(CELLS + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CHECK   = 3'd1,
        S_WRITE   = 3'd2,
        S_ADVANCE = 3'd3,
        S_REJECT  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    col_q, col_d;
    logic [1:0]    piece_q, piece_d;
    logic [2:0]    height_q [COLS];
    logic [2:0]    height_d [COLS];
    logic [PW-1:0] placed_q, placed_d;

    logic [2:0]    cur_height;
    logic          col_valid;
    logic          move_legal;

    // Height of the latched column; col_valid stays low for columns beyond the board.
    always_comb begin
        cur_height = '0;
        col_valid  = 1'b0;
        for (int c = 0; c < COLS; c++) begin
            if (col_q == 3'(c)) begin
                cur_height = height_q[c];
                col_valid  = 1'b1;
            end
        end
    end

    always_comb begin
        for (int c = 0; c < COLS; c++) begin
            col_full[c] = (height_q[c] == 3'(ROWS));
        end
    end

    assign board_full = (placed_q == PW'(CELLS));

    assign move_legal = col_valid
                      && (cur_height != 3'(ROWS))
                      && ((piece_q == 2'b01) || (piece_q == 2'b10))
                      && !board_full;

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        piece_d  = piece_q;
        height_d = height_q;
        placed_d = placed_q;

        case (state_q)
            S_IDLE: begin
                if (drop_req) begin
                    col_d   = drop_col;
                    piece_d = piece;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                state_d = move_legal ? S_WRITE : S_REJECT;
            end
            S_WRITE: begin
                for (int c = 0; c < COLS; c++) begin
                    if ((col_q == 3'(c)) && (height_q[c] != 3'(ROWS))) begin
                        height_d[c] = height_q[c] + 3'd1;
                    end
                end
                if (placed_q != PW'(CELLS)) begin
                    placed_d = placed_q + PW'(1);
                end
                state_d = S_ADVANCE;
            end
            S_ADVANCE: state_d = S_IDLE;
            S_REJECT:  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        // A new game wins over everything, including a move that is mid-flight.
        if (new_game) begin
            state_d = S_IDLE;
            for (int c = 0; c < COLS; c++) begin
                height_d[c] = '0;
            end
            placed_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            col_q    <= '0;
            piece_q  <= '0;
            placed_q <= '0;
            for (int c = 0; c < COLS; c++) begin
                height_q[c] <= '0;
            end
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            piece_q  <= piece_d;
            placed_q <= placed_d;
            height_q <= height_d;
        end
    end

    assign wr_en        = (state_q == S_WRITE);
    assign wr_row       = wr_en ? cur_height : 3'd0;
    assign wr_col       = wr_en ? col_q : 3'd0;
    assign wr_data      = wr_en ? piece_q : 2'd0;
    assign turn_advance = (state_q == S_ADVANCE);
    assign reject       = (state_q == S_REJECT);
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_move_controller.sv
// Randomized bench for move_controller: every cycle of every move is compared against
// a board model that decides legality from the column heights and piece count.
module tb_move_controller;

    localparam int COLS = 7;
    localparam int ROWS = 6;

    logic            clk = 1'b0;
    logic            reset;
    logic            new_game;
    logic            drop_req;
    logic [2:0]      drop_col;
    logic [1:0]      piece;
    logic            wr_en;
    logic [2:0]      wr_row;
    logic [2:0]      wr_col;
    logic [1:0]      wr_data;
    logic            turn_advance;
    logic            reject;
    logic            busy;
    logic [COLS-1:0] col_full;
    logic            board_full;

    move_controller #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk          (clk),
        .reset        (reset),
        .new_game     (new_game),
        .drop_req     (drop_req),
        .drop_col     (drop_col),
        .piece        (piece),
        .wr_en        (wr_en),
        .wr_row       (wr_row),
        .wr_col       (wr_col),
        .wr_data      (wr_data),
        .turn_advance (turn_advance),
        .reject       (reject),
        .busy         (busy),
        .col_full     (col_full),
        .board_full   (board_full)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int h [COLS];
    int placed;
    int mv = 0;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int model_col_full();
        int v = 0;
        for (int c = 0; c < COLS; c++) begin
            if (h[c] == ROWS) v |= (1 << c);
        end
        return v;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < COLS; c++) h[c] = 0;
        placed = 0;
    endtask

    task automatic check_outs(input string tag, input int e_busy, input int e_wr,
                              input int e_row, input int e_col, input int e_data,
                              input int e_ta, input int e_rej);
        check({tag, ".busy"},       int'(busy),         e_busy);
        check({tag, ".wr_en"},      int'(wr_en),        e_wr);
        check({tag, ".wr_row"},     int'(wr_row),       e_row);
        check({tag, ".wr_col"},     int'(wr_col),       e_col);
        check({tag, ".wr_data"},    int'(wr_data),      e_data);
        check({tag, ".turn_adv"},   int'(turn_advance), e_ta);
        check({tag, ".reject"},     int'(reject),       e_rej);
        check({tag, ".col_full"},   int'(col_full),     model_col_full());
        check({tag, ".board_full"}, int'(board_full),   (placed == COLS * ROWS) ? 1 : 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete move; hold keeps drop_req asserted through the whole sequence.
    task automatic do_move(input int col, input int pc, input bit hold);
        bit    legal;
        int    row;
        string t;
        mv++;
        t = $sformatf("mv%0d_c%0d_p%0d", mv, col, pc);
        legal = 1'b0;
        row   = 0;
        if (col < COLS) begin
            legal = (h[col] < ROWS);
            row   = h[col];
        end
        legal = legal && (pc == 1 || pc == 2) && (placed < COLS * ROWS);

        drop_req = 1'b1;
        drop_col = 3'(col);
        piece    = 2'(pc);
        step();
        if (!hold) drop_req = 1'b0;
        check_outs({t, ".e0"}, 1, 0, 0, 0, 0, 0, 0);
        step();
        if (legal) check_outs({t, ".e1"}, 1, 1, row, col, pc, 0, 0);
        else       check_outs({t, ".e1"}, 1, 0, 0, 0, 0, 0, 1);
        step();
        if (legal) begin
            h[col]++;
            placed++;
            check_outs({t, ".e2"}, 1, 0, 0, 0, 0, 1, 0);
            step();
            check_outs({t, ".e3"}, 0, 0, 0, 0, 0, 0, 0);
        end else begin
            check_outs({t, ".e2"}, 0, 0, 0, 0, 0, 0, 0);
        end
    endtask

    task automatic start_new_game();
        new_game = 1'b1;
        step();
        new_game = 1'b0;
        model_clear();
        check_outs("new_game", 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int r, pc, col;
        reset    = 1'b1;
        new_game = 1'b0;
        drop_req = 1'b0;
        drop_col = '0;
        piece    = '0;
        model_clear();
        #12;
        check_outs("reset", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        step();
        check_outs("post_reset", 0, 0, 0, 0, 0, 0, 0);

        // Empty column drop, then a column filled to the top and one more.
        do_move(3, 1, 1'b0);
        start_new_game();
        for (int i = 0; i < ROWS; i++) do_move(0, (i % 2) ? 2 : 1, 1'b0);
        check("col0_full", int'(col_full[0]), 1);
        do_move(0, 1, 1'b0);

        // Illegal column and illegal pieces.
        do_move(7, 1, 1'b0);
        do_move(2, 0, 1'b0);
        do_move(2, 3, 1'b0);

        // drop_req held through a busy move; the next request lands on the first idle edge.
        do_move(4, 2, 1'b1);
        do_move(5, 1, 1'b0);

        repeat (40) begin
            r   = int'($urandom_range(0, 9));
            pc  = (r < 4) ? 1 : (r < 8) ? 2 : (r == 8) ? 0 : 3;
            col = int'($urandom_range(0, 7));
            do_move(col, pc, 1'b0);
        end

        // new_game arriving while a move sits in CHECK drops the write.
        drop_req = 1'b1;
        drop_col = 3'd1;
        piece    = 2'd1;
        step();
        drop_req = 1'b0;
        new_game = 1'b1;
        step();
        new_game = 1'b0;
        model_clear();
        check_outs("ng_abort.e1", 0, 0, 0, 0, 0, 0, 0);
        step();
        check_outs("ng_abort.e2", 0, 0, 0, 0, 0, 0, 0);

        // Fill the whole board in a random column order.
        for (int n = 0; n < COLS * ROWS; n++) begin
            col = int'($urandom_range(0, COLS - 1));
            while (h[col] == ROWS) col = (col + 1) % COLS;
            do_move(col, (n % 2) ? 2 : 1, 1'b0);
        end
        check("board_full_set", int'(board_full), 1);
        do_move(0, 1, 1'b0);
        start_new_game();
        check("board_full_clr", int'(board_full), 0);

        // Asynchronous reset between the accepting edge and the write.
        do_move(2, 2, 1'b0);
        drop_req = 1'b1;
        drop_col = 3'd1;
        piece    = 2'd1;
        step();
        drop_req = 1'b0;
        check("abort.busy_e0", int'(busy), 1);
        #2;
        reset = 1'b1;
        #1;
        model_clear();
        check_outs("abort.immediate", 0, 0, 0, 0, 0, 0, 0);
        step();
        check_outs("abort.in_reset", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_outs($sformatf("abort.after%0d", i), 0, 0, 0, 0, 0, 0, 0);
        end
        do_move(1, 1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
